// File: rtl/melody_sequencer_if.sv
// Board-side bundle for the melody sequencer: player controls, live key,
// melody ROM port and tone generator drive.
interface melody_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [6:0]        key_note;
    logic [ADDR_W-1:0] rom_addr;
    logic [14:0]       rom_data;
    logic [6:0]        full_note;
    logic              play;
    logic              busy;
    logic              done;

    modport master (
        input  start, stop, loop_en, key_note, rom_data,
        output rom_addr, full_note, play, busy, done
    );

    modport slave (
        output start, stop, loop_en, key_note, rom_data,
        input  rom_addr, full_note, play, busy, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Melody ROM player with tempo tick, articulation gap, loop/stop control and
// a live keyboard override sharing one tone generator.
module melody_sequencer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int ADDR_W    = 5,
    parameter int GAP_TICKS = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    melody_sequencer_if.master bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, NOTE, GAP} state_e;

    // The tone generator sounds even on invalid codes, so rests are decoded here.
    function automatic logic is_rest(input logic [6:0] n);
        return (n[3:0] == 4'd0) || (n[3:0] > 4'd12) || (n[6:4] > 3'd4);
    endfunction

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        cur_note_q, cur_note_d;
    logic [7:0]        dur_q, dur_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;
    logic [6:0]        full_note_q, full_note_d;
    logic              play_q, play_d;
    logic              tick, advance, end_song;
    logic [6:0]        rom_note;
    logic [7:0]        rom_dur;

    assign rom_note = bus.rom_data[14:8];
    assign rom_dur  = bus.rom_data[7:0];
    assign tick     = (state_q != IDLE) && (pre_q == PRE_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        advance    = 1'b0;
        end_song   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                if (rom_dur == 8'd0) begin
                    end_song = 1'b1;
                end else begin
                    cur_note_d = rom_note;
                    dur_d      = rom_dur;
                    state_d    = NOTE;
                end
            end
            NOTE: begin
                if (tick) begin
                    dur_d = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        if (GAP_TICKS > 0) begin
                            gap_d   = GAP_W'(GAP_TICKS);
                            state_d = GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Running off the last ROM entry ends the song just like a dur==0 marker.
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                end_song = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = FETCH;
            end
        end
        if (end_song) begin
            addr_d = '0;
            if (bus.loop_en) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        if (bus.stop) begin
            state_d = IDLE;
            addr_d  = '0;
            done_d  = 1'b0;
        end

        if (state_q == IDLE || state_d == IDLE || pre_q == PRE_LAST) pre_d = '0;
        else                                                          pre_d = pre_q + PRE_W'(1);
    end

    // Live key wins over the song; song timing keeps running underneath.
    always_comb begin
        full_note_d = 7'd0;
        play_d      = 1'b1;
        if (!is_rest(bus.key_note)) begin
            full_note_d = bus.key_note;
            play_d      = 1'b0;
        end else if (state_q == NOTE && !is_rest(cur_note_q)) begin
            full_note_d = cur_note_q;
            play_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            addr_q      <= '0;
            cur_note_q  <= 7'd0;
            dur_q       <= 8'd0;
            gap_q       <= '0;
            done_q      <= 1'b0;
            full_note_q <= 7'd0;
            play_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            addr_q      <= addr_d;
            cur_note_q  <= cur_note_d;
            dur_q       <= dur_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            full_note_q <= full_note_d;
            play_q      <= play_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.full_note = full_note_q;
    assign bus.play      = play_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: scoreboard of output segments plus cycle-exact
// scenario checks at 10 clocks per tick.
module tb_melody_sequencer;
    localparam int CLK_HZ = 10, TICK_HZ = 1, ADDR_W = 3, GAP_TICKS = 1;
    localparam int TPT = CLK_HZ / TICK_HZ;

    typedef struct {
        logic [6:0] note;
        logic       play;
        int         ticks;
    } seg_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    melody_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    melody_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADDR_W(ADDR_W), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [14:0] rom [8];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int total = 0;
    int bad = 0;

    // Monitor: closes a segment each time {full_note, play} changes.
    int         obs_cnt = 0;
    int         mon_len = 0;
    int         done_cnt = 0;
    logic [7:0] mon_val = 8'h01;
    logic [7:0] obs_v [512];
    int         obs_len [512];
    seg_t       exp_q [$];

    always @(negedge clk) begin
        if ({bus.full_note, bus.play} !== mon_val) begin
            obs_v[obs_cnt % 512]   <= mon_val;
            obs_len[obs_cnt % 512] <= mon_len;
            obs_cnt <= obs_cnt + 1;
            mon_val <= {bus.full_note, bus.play};
            mon_len <= 1;
        end else begin
            mon_len <= mon_len + 1;
        end
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic expect_seg(input logic [6:0] n, input logic p, input int t);
        seg_t s;
        s.note = n; s.play = p; s.ticks = t;
        exp_q.push_back(s);
    endtask

    task automatic wait_obs(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (obs_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic load_basic();
        foreach (rom[i]) rom[i] = 15'h0;
        rom[0] = {7'h0A, 8'd3};
        rom[1] = {7'h1A, 8'd2};
    endtask

    task automatic test_reset();
        bit hold_ok;
        repeat (3) @(negedge clk);
        total++;
        if (bus.play !== 1'b1 || bus.full_note !== 7'h0 || bus.busy !== 1'b0 || bus.rom_addr !== 3'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: play=%b note=%h busy=%b addr=%0d done=%b", bus.play, bus.full_note, bus.busy, bus.rom_addr, bus.done);
        end
        reset_n = 1'b1;
        load_basic();
        pulse_start();
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.play !== 1'b1 || bus.full_note !== 7'h0 || bus.busy !== 1'b0 || bus.rom_addr !== 3'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: play=%b note=%h busy=%b addr=%0d, want 1/00/0/0", bus.play, bus.full_note, bus.busy, bus.rom_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hold_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.play !== 1'b1 || bus.full_note !== 7'h0 || bus.busy !== 1'b0 || bus.rom_addr !== 3'd0) hold_ok = 1'b0;
        end
        total++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL reset_hold: outputs left idle values without start, last play=%b busy=%b", bus.play, bus.busy);
        end
    endtask

    task automatic test_basic();
        bit ok; int base, d0; seg_t e; int idx;
        exp_q.delete();
        load_basic();
        bus.loop_en = 1'b0;
        base = obs_cnt; d0 = done_cnt;
        expect_seg(7'h00, 1'b1, 0);
        expect_seg(7'h0A, 1'b0, 3);
        expect_seg(7'h00, 1'b1, 1);
        expect_seg(7'h1A, 1'b0, 2);
        pulse_start();
        wait_obs(base + 4, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_segs: got %0d segments want 4", obs_cnt - base); end
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_busy: busy=%b want 0", bus.busy); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            idx = (base + k) % 512;
            total++;
            if (obs_v[idx] !== {e.note, e.play} || (e.ticks > 0 && (obs_len[idx] < (e.ticks - 1) * TPT || obs_len[idx] > (e.ticks + 1) * TPT))) begin
                bad++;
                $display("FAIL basic_seg%0d: got note=%h play=%b len=%0d want note=%h play=%b ticks=%0d", k, obs_v[idx][7:1], obs_v[idx][0], obs_len[idx], e.note, e.play, e.ticks);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done: pulses=%0d want 1", done_cnt - d0); end
        total++;
        if (bus.rom_addr !== 3'd0 || bus.play !== 1'b1) begin
            bad++; $display("FAIL basic_end: addr=%0d play=%b want 0/1", bus.rom_addr, bus.play);
        end
    endtask

    task automatic test_loop();
        bit ok; int base, d0; seg_t e; int idx;
        exp_q.delete();
        load_basic();
        bus.loop_en = 1'b1;
        base = obs_cnt; d0 = done_cnt;
        expect_seg(7'h00, 1'b1, 0);
        for (int r = 0; r < 2; r++) begin
            expect_seg(7'h0A, 1'b0, 3);
            expect_seg(7'h00, 1'b1, 1);
            expect_seg(7'h1A, 1'b0, 2);
            if (r == 0) expect_seg(7'h00, 1'b1, 1);
        end
        pulse_start();
        wait_obs(base + 5, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL loop_replay: got %0d segments want 5", obs_cnt - base); end
        @(negedge clk);
        total++;
        if (done_cnt !== d0 || bus.rom_addr !== 3'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL loop_wrap: done=%0d addr=%0d busy=%b want 0/0/1", done_cnt - d0, bus.rom_addr, bus.busy);
        end
        bus.loop_en = 1'b0;
        wait_obs(base + 8, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL loop_segs: got %0d segments want 8", obs_cnt - base); end
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL loop_busy: busy=%b want 0", bus.busy); end
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            idx = (base + k) % 512;
            total++;
            if (obs_v[idx] !== {e.note, e.play} || (e.ticks > 0 && (obs_len[idx] < (e.ticks - 1) * TPT || obs_len[idx] > (e.ticks + 1) * TPT))) begin
                bad++;
                $display("FAIL loop_seg%0d: got note=%h play=%b len=%0d want note=%h play=%b ticks=%0d", k, obs_v[idx][7:1], obs_v[idx][0], obs_len[idx], e.note, e.play, e.ticks);
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL loop_done: pulses=%0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stop();
        bit ok; int d0;
        load_basic();
        @(negedge clk); bus.start = 1'b1; bus.stop = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.rom_addr !== 3'd0) begin
            bad++; $display("FAIL stop_prio: busy=%b addr=%0d want 0/0", bus.busy, bus.rom_addr);
        end
        bus.start = 1'b0; bus.stop = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.full_note === 7'h0A) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stop_note: full_note=%h want 0a", bus.full_note); end
        d0 = done_cnt;
        bus.stop = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.rom_addr !== 3'd0) begin
            bad++; $display("FAIL stop_idle: busy=%b addr=%0d want 0/0", bus.busy, bus.rom_addr);
        end
        bus.stop = 1'b0;
        @(negedge clk);
        total++;
        if (bus.play !== 1'b1 || bus.full_note !== 7'h0) begin
            bad++; $display("FAIL stop_mute: play=%b note=%h want 1/00", bus.play, bus.full_note);
        end
        repeat (100) @(negedge clk);
        total++;
        if (done_cnt !== d0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL stop_nodone: pulses=%0d busy=%b want 0/0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_override();
        int done_at;
        load_basic();
        bus.loop_en = 1'b0;
        done_at = -1;
        @(negedge clk); bus.start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 4 || c == 16 || c == 21 || c == 31) begin
                total++;
                if (bus.full_note !== 7'h0A || bus.play !== 1'b0) begin
                    bad++; $display("FAIL ovr_song c=%0d: note=%h play=%b want 0a/0", c, bus.full_note, bus.play);
                end
            end
            if (c == 11) begin
                total++;
                if (bus.full_note !== 7'h41 || bus.play !== 1'b0) begin
                    bad++; $display("FAIL ovr_key: note=%h play=%b want 41/0", bus.full_note, bus.play);
                end
            end
            if (c == 32) begin
                total++;
                if (bus.full_note !== 7'h00 || bus.play !== 1'b1) begin
                    bad++; $display("FAIL ovr_gap: note=%h play=%b want 00/1", bus.full_note, bus.play);
                end
            end
            if (bus.done === 1'b1 && done_at < 0) done_at = c;
            if (c == 10) bus.key_note = 7'h41;
            if (c == 15) bus.key_note = 7'h00;
            if (c == 20) bus.key_note = 7'h0D;
            if (c == 22) bus.key_note = 7'h00;
        end
        total++;
        if (done_at !== 73) begin bad++; $display("FAIL ovr_timing: done at cycle %0d want 73", done_at); end
    endtask

    task automatic test_rest();
        bit quiet; int done_at;
        foreach (rom[i]) rom[i] = 15'h0;
        rom[0] = {7'h0D, 8'd2};
        rom[1] = {7'h50, 8'd2};
        rom[2] = {7'h0A, 8'd1};
        quiet = 1'b1; done_at = -1;
        @(negedge clk); bus.start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c <= 63 && (bus.play !== 1'b1 || bus.full_note !== 7'h0)) quiet = 1'b0;
            if (c == 45) begin
                total++;
                if (bus.busy !== 1'b1) begin bad++; $display("FAIL rest_busy: busy=%b want 1", bus.busy); end
            end
            if (c == 64 || c == 71) begin
                total++;
                if (bus.full_note !== 7'h0A || bus.play !== 1'b0) begin
                    bad++; $display("FAIL rest_next c=%0d: note=%h play=%b want 0a/0", c, bus.full_note, bus.play);
                end
            end
            if (c == 72) begin
                total++;
                if (bus.play !== 1'b1) begin bad++; $display("FAIL rest_after: play=%b want 1", bus.play); end
            end
            if (bus.done === 1'b1 && done_at < 0) done_at = c;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL rest_silent: rest entries produced sound, quiet=%b want 1", quiet); end
        total++;
        if (done_at !== 83) begin bad++; $display("FAIL rest_done: done at cycle %0d want 83", done_at); end
    endtask

    task automatic test_wrap();
        bit ok; int base, d0; seg_t e; int idx;
        exp_q.delete();
        for (int i = 0; i < 8; i++) rom[i] = {7'(i + 1), 8'd1};
        bus.loop_en = 1'b0;
        base = obs_cnt; d0 = done_cnt;
        expect_seg(7'h00, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            expect_seg(7'(i + 1), 1'b0, 1);
            if (i < 7) expect_seg(7'h00, 1'b1, 1);
        end
        pulse_start();
        wait_obs(base + 16, 800, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_segs: got %0d segments want 16", obs_cnt - base); end
        wait_idle(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_busy: busy=%b want 0", bus.busy); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            idx = (base + k) % 512;
            total++;
            if (obs_v[idx] !== {e.note, e.play} || (e.ticks > 0 && (obs_len[idx] < (e.ticks - 1) * TPT || obs_len[idx] > (e.ticks + 1) * TPT))) begin
                bad++;
                $display("FAIL wrap_seg%0d: got note=%h play=%b len=%0d want note=%h play=%b ticks=%0d", k, obs_v[idx][7:1], obs_v[idx][0], obs_len[idx], e.note, e.play, e.ticks);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || bus.rom_addr !== 3'd0) begin
            bad++; $display("FAIL wrap_done: pulses=%0d addr=%0d want 1/0", done_cnt - d0, bus.rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        load_basic();
        bus.loop_en = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_done: done never pulsed, done=%b", bus.done); end
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: busy=%b want 1", bus.busy); end
        bus.start = 1'b0; bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.key_note = 7'h0;
        foreach (rom[i]) rom[i] = 15'h0;
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_override();
        test_rest();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Autonomous song player that drives the piano tone generator's note-select and mute inputs (`full_note`, `play`).
- Steps through a melody ROM of {note, duration} entries, with a tempo tick, a silent articulation gap after each note, and loop/stop control.
- A live keyboard note overrides the sequencer output while held, so one tone generator serves both requesters.
- Sits between the board switches/keys, the melody ROM, and the tone generator.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, duration unit rate; one tick = 1 ms at default.
- ADDR_W, 5, melody ROM address width (32 entries).
- GAP_TICKS, 20, silent ticks inserted after every note; 0 = no gap.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level; begin playback from entry 0 when idle.
- stop  in  1  level; abort playback, priority over start.
- loop_en  in  1  on end-of-song, restart at entry 0 instead of finishing.
- key_note  in  7  live keyboard code; 0 = no key held.
- rom_addr  out  ADDR_W  melody ROM address, registered.
- rom_data  in  15  {note[14:8], dur[7:0]}; synchronous ROM, valid 1 cycle after rom_addr.
- full_note  out  7  note code to tone generator, registered.
- play  out  1  tone generator mute, active-high; 1 = silent.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on natural song completion.

Behaviour:
- Reset, async while reset_n=0: state=IDLE, rom_addr=0, full_note=0, play=1, busy=0, done=0, all counters 0.
- Tick prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1; tick = 1-cycle strobe at terminal count.
  - Cleared on leaving IDLE; frozen at 0 in IDLE.
- FSM states: IDLE, FETCH, LOAD, NOTE, GAP.
- IDLE:
  - start=1 and stop=0 -> FETCH, with rom_addr=0, busy=1.
- FETCH:
  - One wait cycle for the ROM -> LOAD.
- LOAD, samples rom_data:
  - dur==0 is the end marker. If loop_en=1: rom_addr<=0, -> FETCH. Else: done=1 for one cycle, -> IDLE, busy=0.
  - Otherwise: cur_note<=note, dur_cnt<=dur, -> NOTE.
- NOTE:
  - Sequencer note = cur_note.
  - dur_cnt decrements on each tick. On the tick where dur_cnt==1:
    - GAP_TICKS>0: gap_cnt<=GAP_TICKS, -> GAP.
    - GAP_TICKS=0: advance, -> FETCH.
- GAP:
  - Sequencer output silent.
  - gap_cnt decrements per tick; on the tick where gap_cnt==1, advance, -> FETCH.
- Advance:
  - rom_addr+1.
  - If rom_addr is 2^ADDR_W-1, wrap is treated as an end marker, handled identically to dur==0 (loop or done).
- Note duration:
  - From entry into NOTE to exit is dur ticks; first tick may be partial by ≤1 tick period, since the prescaler free-runs.
- Rest detection (tone generator is not silent on invalid or zero codes):
  - A code is a rest if note[3:0]==0, note[3:0]>12, or note[6:4]>4.
  - Rest codes force play=1 and full_note=0.
- Output arbitration, registered with 1-cycle latency:
  - key_note!=0 and not a rest: full_note=key_note, play=0, in any state.
  - Otherwise, NOTE state with a non-rest cur_note: full_note=cur_note, play=0.
  - Otherwise: full_note=0, play=1.
  - Sequencer timing continues during override; no pause.
- stop:
  - stop=1 in any state -> IDLE next cycle; rom_addr=0, busy=0, no done pulse.
  - Live key override still works.
  - start and stop both high: stop wins.
- start while busy: ignored; start held high after completion restarts immediately.
- loop_en: sampled only at end-of-song; may change mid-song.
- Widths:
  - dur_cnt 8 bits; gap_cnt ≥ clog2(GAP_TICKS+1).
  - Prescaler ≥ clog2(CLK_HZ/TICK_HZ) bits; no counter overflows for legal parameters.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (10 cycles/tick), GAP_TICKS=1, ADDR_W=3.
- Reset/idle:
  - Stimulus: reset_n low mid-operation, then high with no start.
  - Required: play=1, full_note=0, busy=0, rom_addr=0, held indefinitely.
- Basic song:
  - Stimulus: ROM {0x0A,3},{0x1A,2},{0x00,0}; start pulse.
  - Required: full_note=0x0A/play=0 for 3 ticks (±1); silent 1 tick; 0x1A for 2 ticks; silent 1 tick; done pulses once; busy falls.
- Loop:
  - Stimulus: same ROM with loop_en=1.
  - Required: after the end marker, rom_addr returns to 0 and 0x0A replays; no done. Clearing loop_en mid-song gives done after the following end marker.
- Stop priority:
  - Stimulus: start=stop=1 in IDLE.
  - Required: stays IDLE.
  - Stimulus: stop asserted mid-NOTE.
  - Required: next cycle IDLE, play=1, no done.
- Live override:
  - Stimulus: key_note=0x41 during the 0x0A note.
  - Required: full_note=0x41, play=0 one cycle later. Release: output reverts to 0x0A, with song timing unchanged.
- Rests/wrap:
  - Stimulus: entry note 0x0D or 0x50 with dur 2.
  - Required: play=1 for 2 ticks.
  - Stimulus: 8 entries with no marker, loop_en=0.
  - Required: after entry 7, done pulses and rom_addr=0.
